// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the machine-mode CSR file and trap sequencer:
//   - CSR address map
//   - csr_op encodings and the per-cycle action chosen by the sequencer
//   - trap cause codes
//   - bit positions inside mstatus / mie / mip
// Optional build macro used by the importing RTL: CSR_COUNTERS_EN.
// -----------------------------------------------------------------------------
package csr_pkg;

  // CSR address map
  localparam logic [11:0] CSR_ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_ADDR_MIE      = 12'h304;
  localparam logic [11:0] CSR_ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_ADDR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_ADDR_MIP      = 12'h344;
  localparam logic [11:0] CSR_ADDR_MHARTID  = 12'hF14;
  localparam logic [11:0] CSR_ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_ADDR_MINSTRET = 12'hB02;

  // csr_op encodings; 3'b110 / 3'b111 behave like CSR_OP_NONE
  typedef enum logic [2:0] {
    CSR_OP_NONE  = 3'b000,
    CSR_OP_RW    = 3'b001,
    CSR_OP_RS    = 3'b010,
    CSR_OP_RC    = 3'b011,
    CSR_OP_ECALL = 3'b100,
    CSR_OP_MRET  = 3'b101
  } csr_op_e;

  // What the unit does with the current instruction, after priority resolution
  typedef enum logic [2:0] {
    ACT_IDLE    = 3'd0,  // no instruction this cycle
    ACT_IRQ     = 3'd1,  // timer interrupt taken, instruction suppressed
    ACT_ILLEGAL = 3'd2,  // illegal-CSR exception
    ACT_ECALL   = 3'd3,  // environment call exception
    ACT_MRET    = 3'd4,  // return from trap
    ACT_CSR_WR  = 3'd5,  // CSR read-modify-write that updates a register
    ACT_RETIRE  = 3'd6   // retires with no CSR side effect
  } act_e;

  // Trap cause codes
  localparam int unsigned CAUSE_ILLEGAL_INSN = 2;
  localparam int unsigned CAUSE_MTIMER_IRQ   = 7;
  localparam int unsigned CAUSE_ECALL_M      = 11;

  // Vectored mode places each interrupt handler 4 bytes * cause past the base
  localparam int unsigned IRQ_VECTOR_STRIDE = 4;

  // Bit positions
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_HI   = 12;
  localparam int unsigned MSTATUS_MPP_LO   = 11;
  localparam int unsigned MIE_MTIE_BIT     = 7;
  localparam int unsigned MIP_MTIP_BIT     = 7;

  // Read-only CSRs fault on any op that would write them
  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return (addr == CSR_ADDR_MIP) || (addr == CSR_ADDR_MHARTID);
  endfunction

endpackage

// File: rtl/csr_sync2.sv
// -----------------------------------------------------------------------------
// csr_sync2
// Two-flop synchroniser for asynchronous level inputs (used for mtip).
// A rising input is visible on sync_o after two clk rising edges.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (both stages clear to 0)
//   async_i  in   WIDTH  asynchronous input
//   sync_o   out  WIDTH  synchronised output
// -----------------------------------------------------------------------------
module csr_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/csr_trap_unit.sv
// -----------------------------------------------------------------------------
// csr_trap_unit
// Machine-mode CSR file plus trap sequencer for the single-issue core.
// Executes CSRRW/CSRRS/CSRRC (register and zimm forms), ECALL and MRET, raises
// illegal-CSR exceptions and takes the machine timer interrupt, stacking
// mstatus MIE/MPIE and redirecting fetch through mtvec (direct or vectored).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   inst_valid    in   the instruction on pc/csr_* retires this cycle
//   pc            in   XLEN  PC of that instruction
//   csr_op        in   3     000 none, 001 RW, 010 RS, 011 RC, 100 ECALL, 101 MRET
//   csr_addr      in   12    CSR address
//   csr_wsrc      in   XLEN  rs1 value or zero-extended zimm
//   csr_rdata     out  XLEN  old value of the addressed CSR (combinational)
//   redirect      out  trap entry or MRET this cycle (combinational)
//   redirect_pc   out  XLEN  fetch target when redirect=1, else 0
//   illegal       out  current op faults
//   mtip          in   asynchronous machine timer interrupt request
//   irq_taken     out  interrupt accepted; the instruction is suppressed
//
// Handshake: there is no backpressure. inst_valid qualifies pc/csr_op/
// csr_addr/csr_wsrc for exactly one cycle; all architectural updates for that
// instruction land on the next clk rising edge, and redirect/illegal/irq_taken
// are only ever asserted in a cycle where inst_valid=1.
//
// Build option: define CSR_COUNTERS_EN to add mcycle (0xB00) and
// minstret (0xB02); otherwise those addresses are unimplemented.
// -----------------------------------------------------------------------------
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RST   = '0,
  parameter logic [63:0]     MSTATUS_RST = 64'h0000_000A_0000_1800,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wsrc,
  output logic [XLEN-1:0] csr_rdata,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal,
  input  logic            mtip,
  output logic            irq_taken
);

  localparam logic [XLEN-1:0] MSTATUS_RST_X = MSTATUS_RST[XLEN-1:0];
  localparam logic [XLEN-1:0] MEPC_MASK     = ~XLEN'(3);
  localparam logic [XLEN-1:0] MTVEC_MASK    = ~XLEN'(2);
  localparam logic [XLEN-1:0] BASE_MASK     = ~XLEN'(3);
  localparam logic [XLEN-1:0] MCAUSE_IRQ    = {1'b1, (XLEN-1)'(CAUSE_MTIMER_IRQ)};
  localparam logic [XLEN-1:0] MCAUSE_ILL    = XLEN'(CAUSE_ILLEGAL_INSN);
  localparam logic [XLEN-1:0] MCAUSE_ECALL  = XLEN'(CAUSE_ECALL_M);
  localparam logic [XLEN-1:0] IRQ_OFFSET    = XLEN'(IRQ_VECTOR_STRIDE * CAUSE_MTIMER_IRQ);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic            mstatus_mie_q,  mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            mie_mtie_q,     mie_mtie_d;
  logic [XLEN-1:0] mtvec_q,        mtvec_d;
  logic [XLEN-1:0] mscratch_q,     mscratch_d;
  logic [XLEN-1:0] mepc_q,         mepc_d;
  logic [XLEN-1:0] mcause_q,       mcause_d;
  logic [XLEN-1:0] mtval_q,        mtval_d;
`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle_q,       mcycle_d;
  logic [XLEN-1:0] minstret_q,     minstret_d;
`endif

  logic            mtip_sync;

  // Combinational views and decode
  logic [XLEN-1:0] mstatus_val, mie_val, mip_val;
  logic [XLEN-1:0] csr_old, csr_wdata, trap_base;
  logic            csr_hit, csr_ro;
  logic            is_csr_op, wsrc_nz, wr_attempt, op_fault, irq_pending;
  act_e            act;

  csr_sync2 #(.WIDTH(1)) u_mtip_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (mtip),
    .sync_o  (mtip_sync)
  );

  // Architectural views of the partially implemented registers. Bits of
  // mstatus other than MIE/MPIE/MPP are constant and come from the reset value.
  always_comb begin
    mstatus_val                                  = MSTATUS_RST_X;
    mstatus_val[MSTATUS_MIE_BIT]                 = mstatus_mie_q;
    mstatus_val[MSTATUS_MPIE_BIT]                = mstatus_mpie_q;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = 2'b11;
    mie_val                                      = '0;
    mie_val[MIE_MTIE_BIT]                        = mie_mtie_q;
    mip_val                                      = '0;
    mip_val[MIP_MTIP_BIT]                        = mtip_sync;
  end

  // Read mux
  always_comb begin
    csr_hit = 1'b1;
    csr_ro  = csr_is_read_only(csr_addr);
    csr_old = '0;
    case (csr_addr)
      CSR_ADDR_MSTATUS:  csr_old = mstatus_val;
      CSR_ADDR_MIE:      csr_old = mie_val;
      CSR_ADDR_MTVEC:    csr_old = mtvec_q;
      CSR_ADDR_MSCRATCH: csr_old = mscratch_q;
      CSR_ADDR_MEPC:     csr_old = mepc_q;
      CSR_ADDR_MCAUSE:   csr_old = mcause_q;
      CSR_ADDR_MTVAL:    csr_old = mtval_q;
      CSR_ADDR_MIP:      csr_old = mip_val;
      CSR_ADDR_MHARTID:  csr_old = HART_ID;
      CSR_ADDR_MCYCLE: begin
`ifdef CSR_COUNTERS_EN
        csr_old = mcycle_q;
`else
        csr_hit = 1'b0;
`endif
      end
      CSR_ADDR_MINSTRET: begin
`ifdef CSR_COUNTERS_EN
        csr_old = minstret_q;
`else
        csr_hit = 1'b0;
`endif
      end
      default:           csr_hit = 1'b0;
    endcase
  end

  // Decode and priority resolution. RS/RC with a zero source is a pure read
  // (judged on the value, not on the rs1 index), so it never writes and never
  // faults on a read-only CSR.
  always_comb begin
    is_csr_op   = (csr_op == CSR_OP_RW) || (csr_op == CSR_OP_RS) || (csr_op == CSR_OP_RC);
    wsrc_nz     = |csr_wsrc;
    wr_attempt  = (csr_op == CSR_OP_RW) ||
                  (((csr_op == CSR_OP_RS) || (csr_op == CSR_OP_RC)) && wsrc_nz);
    op_fault    = is_csr_op && (!csr_hit || (csr_ro && wr_attempt));
    irq_pending = mstatus_mie_q && mie_mtie_q && mtip_sync;

    act = ACT_IDLE;
    if (inst_valid) begin
      if (irq_pending)                    act = ACT_IRQ;
      else if (op_fault)                  act = ACT_ILLEGAL;
      else if (csr_op == CSR_OP_ECALL)    act = ACT_ECALL;
      else if (csr_op == CSR_OP_MRET)     act = ACT_MRET;
      else if (is_csr_op && wr_attempt)   act = ACT_CSR_WR;
      else                                act = ACT_RETIRE;
    end
  end

  always_comb begin
    case (csr_op)
      CSR_OP_RS: csr_wdata = csr_old | csr_wsrc;
      CSR_OP_RC: csr_wdata = csr_old & ~csr_wsrc;
      default:   csr_wdata = csr_wsrc;
    endcase
  end

  assign trap_base = mtvec_q & BASE_MASK;

  // Outputs. Everything is held low while reset is asserted so a trap in
  // flight is dropped immediately.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    illegal     = 1'b0;
    irq_taken   = 1'b0;
    csr_rdata   = (rst_n && is_csr_op) ? csr_old : '0;
    if (rst_n) begin
      case (act)
        ACT_IRQ: begin
          redirect    = 1'b1;
          irq_taken   = 1'b1;
          redirect_pc = mtvec_q[0] ? (trap_base + IRQ_OFFSET) : trap_base;
        end
        ACT_ILLEGAL: begin
          redirect    = 1'b1;
          illegal     = 1'b1;
          redirect_pc = trap_base;
        end
        ACT_ECALL: begin
          redirect    = 1'b1;
          redirect_pc = trap_base;
        end
        ACT_MRET: begin
          redirect    = 1'b1;
          redirect_pc = mepc_q;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
`ifdef CSR_COUNTERS_EN
    mcycle_d       = mcycle_q + XLEN'(1);
    // Suppressed instructions (interrupt, illegal) do not retire
    minstret_d     = minstret_q;
    if ((act == ACT_ECALL) || (act == ACT_MRET) || (act == ACT_CSR_WR) || (act == ACT_RETIRE))
      minstret_d = minstret_q + XLEN'(1);
`endif

    case (act)
      ACT_IRQ, ACT_ILLEGAL, ACT_ECALL: begin
        mepc_d         = pc & MEPC_MASK;
        mtval_d        = '0;
        mstatus_mpie_d = mstatus_mie_q;
        mstatus_mie_d  = 1'b0;
        if (act == ACT_IRQ)          mcause_d = MCAUSE_IRQ;
        else if (act == ACT_ILLEGAL) mcause_d = MCAUSE_ILL;
        else                         mcause_d = MCAUSE_ECALL;
      end
      ACT_MRET: begin
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
      end
      ACT_CSR_WR: begin
        // A CSR write beats the counter increment of the same cycle
        case (csr_addr)
          CSR_ADDR_MSTATUS: begin
            mstatus_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
            mstatus_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
          end
          CSR_ADDR_MIE:      mie_mtie_d = csr_wdata[MIE_MTIE_BIT];
          CSR_ADDR_MTVEC:    mtvec_d    = csr_wdata & MTVEC_MASK;
          CSR_ADDR_MSCRATCH: mscratch_d = csr_wdata;
          CSR_ADDR_MEPC:     mepc_d     = csr_wdata & MEPC_MASK;
          CSR_ADDR_MCAUSE:   mcause_d   = csr_wdata;
          CSR_ADDR_MTVAL:    mtval_d    = csr_wdata;
`ifdef CSR_COUNTERS_EN
          CSR_ADDR_MCYCLE:   mcycle_d   = csr_wdata;
          CSR_ADDR_MINSTRET: minstret_d = csr_wdata;
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= MSTATUS_RST_X[MSTATUS_MIE_BIT];
      mstatus_mpie_q <= MSTATUS_RST_X[MSTATUS_MPIE_BIT];
      mie_mtie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RST & MTVEC_MASK;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle_q       <= '0;
      minstret_q     <= '0;
`endif
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
`endif
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_trap_unit
// Table-driven bench for csr_trap_unit (default parameters, XLEN=64).
// Each table row drives one instruction cycle; its expected outputs go into
// exp_q when driven and are popped and compared mid-cycle. CSR state is
// observed through RS-with-zero reads. Hand-written sequences cover the
// reset-time outputs and an asynchronous reset in the middle of an ECALL.
// -----------------------------------------------------------------------------
module tb_csr_trap_unit;

  localparam int XLEN = 64;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_RW    = 3'b001;
  localparam logic [2:0] OP_RS    = 3'b010;
  localparam logic [2:0] OP_RC    = 3'b011;
  localparam logic [2:0] OP_ECALL = 3'b100;
  localparam logic [2:0] OP_MRET  = 3'b101;

  localparam logic [63:0] MS = 64'h0000_000A_0000_1800;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic            inst_valid;
  logic [XLEN-1:0] pc;
  logic [2:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wsrc;
  logic [XLEN-1:0] csr_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            illegal;
  logic            mtip;
  logic            irq_taken;

  always #5 clk = ~clk;

  csr_trap_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wsrc    (csr_wsrc),
    .csr_rdata   (csr_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .illegal     (illegal),
    .mtip        (mtip),
    .irq_taken   (irq_taken)
  );

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [63:0] wsrc;
    logic        mtip;
    logic        e_red;
    logic        e_ill;
    logic        e_irq;
    logic [63:0] e_rpc;
    logic [63:0] e_rdata;
  } vec_t;

  typedef logic [130:0] exp_t;  // {redirect, illegal, irq_taken, redirect_pc, csr_rdata}

  exp_t exp_q[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic valid, input logic [63:0] vpc,
                              input logic [2:0] op, input logic [11:0] addr,
                              input logic [63:0] wsrc, input logic vmtip,
                              input logic e_red, input logic e_ill, input logic e_irq,
                              input logic [63:0] e_rpc, input logic [63:0] e_rdata);
    vec_t v;
    v.valid = valid; v.pc = vpc; v.op = op; v.addr = addr; v.wsrc = wsrc; v.mtip = vmtip;
    v.e_red = e_red; v.e_ill = e_ill; v.e_irq = e_irq; v.e_rpc = e_rpc; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Plain read of a CSR: RS with zero source, no side effects expected
  function automatic vec_t rd(input logic [11:0] addr, input logic vmtip, input logic [63:0] e_rdata);
    return mk(1'b1, 64'h0, OP_RS, addr, 64'h0, vmtip, 1'b0, 1'b0, 1'b0, 64'h0, e_rdata);
  endfunction

  task automatic check(input string what, input int idx, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", what, idx, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    inst_valid = v.valid;
    pc         = v.pc;
    csr_op     = v.op;
    csr_addr   = v.addr;
    csr_wsrc   = v.wsrc;
    mtip       = v.mtip;
    exp_q.push_back({v.e_red, v.e_ill, v.e_irq, v.e_rpc, v.e_rdata});
  endtask

  task automatic compare(input int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty vec=%0d got=0 want=1", idx);
    end else begin
      e = exp_q.pop_front();
      check("redirect",    idx, 64'(redirect),  64'(e[130]));
      check("illegal",     idx, 64'(illegal),   64'(e[129]));
      check("irq_taken",   idx, 64'(irq_taken), 64'(e[128]));
      check("redirect_pc", idx, redirect_pc,    e[127:64]);
      check("csr_rdata",   idx, csr_rdata,      e[63:0]);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are compared on
  // the falling edge of the same cycle.
  task automatic run_vec(input vec_t v, input int idx);
    drive(v);
    @(negedge clk);
    compare(idx);
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    // Main table
    vecs.push_back(rd(12'h300, 0, MS));                                                   // 0 reset mstatus
    vecs.push_back(rd(12'h305, 0, 64'h0));                                                // 1 reset mtvec
    vecs.push_back(mk(1, 0, OP_RW, 12'h305, 64'h8000_1001, 0, 0, 0, 0, 0, 64'h0));        // 2
    vecs.push_back(rd(12'h305, 0, 64'h8000_1001));                                        // 3
    vecs.push_back(mk(1, 64'h8000_0100, OP_ECALL, 0, 0, 0, 1, 0, 0, 64'h8000_1000, 0));   // 4 ECALL
    vecs.push_back(rd(12'h341, 0, 64'h8000_0100));                                        // 5 mepc
    vecs.push_back(rd(12'h342, 0, 64'd11));                                               // 6 mcause
    vecs.push_back(rd(12'h300, 0, MS));                                                   // 7 MIE=0
    vecs.push_back(rd(12'h344, 1, 64'h0));                                                // 8 mtip rises
    vecs.push_back(rd(12'h344, 1, 64'h0));                                                // 9 one edge
    vecs.push_back(rd(12'h344, 1, 64'h80));                                               // 10 two edges
    vecs.push_back(mk(1, 0, OP_RW, 12'h304, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 0, 0));  // 11 MTIE
    vecs.push_back(rd(12'h304, 1, 64'h80));                                               // 12
    vecs.push_back(mk(1, 0, OP_RS, 12'h300, 64'h8, 1, 0, 0, 0, 0, MS));                   // 13 set MIE
    vecs.push_back(mk(1, 64'h8000_0200, OP_NONE, 0, 0, 1, 1, 0, 1, 64'h8000_101C, 0));    // 14 IRQ
    vecs.push_back(rd(12'h342, 1, 64'h8000_0000_0000_0007));                              // 15
    vecs.push_back(rd(12'h300, 1, MS | 64'h80));                                          // 16 MPIE=1 MIE=0
    vecs.push_back(rd(12'h341, 1, 64'h8000_0200));                                        // 17
    vecs.push_back(mk(1, 0, OP_RW, 12'h341, 64'h8000_0104, 0, 0, 0, 0, 0, 64'h8000_0200));// 18
    vecs.push_back(mk(1, 0, OP_MRET, 0, 0, 0, 1, 0, 0, 64'h8000_0104, 0));                // 19 MRET
    vecs.push_back(rd(12'h300, 0, MS | 64'h88));                                          // 20
    vecs.push_back(rd(12'h344, 0, 64'h0));                                                // 21
    vecs.push_back(mk(1, 64'h8000_0300, OP_RW, 12'hF14, 64'h5, 0, 1, 1, 0, 64'h8000_1000, 0)); // 22
    vecs.push_back(rd(12'h342, 0, 64'd2));                                                // 23
    vecs.push_back(rd(12'hF14, 0, 64'h0));                                                // 24 RS x0 ok
    vecs.push_back(rd(12'h300, 0, MS | 64'h80));                                          // 25 stacked
    vecs.push_back(mk(1, 64'h8000_0400, OP_RS, 12'h7C0, 0, 0, 1, 1, 0, 64'h8000_1000, 0));// 26 unimpl
`ifndef CSR_COUNTERS_EN
    vecs.push_back(mk(1, 64'h8000_0400, OP_RS, 12'hB00, 0, 0, 1, 1, 0, 64'h8000_1000, 0));// mcycle absent
`endif
    vecs.push_back(mk(1, 0, OP_RS, 12'h300, 64'h80, 0, 0, 0, 0, 0, MS));                  // set MPIE
    vecs.push_back(mk(1, 0, OP_RC, 12'h300, 64'h80, 0, 0, 0, 0, 0, MS | 64'h80));         // clear MPIE
    vecs.push_back(rd(12'h300, 0, MS));
    vecs.push_back(mk(1, 0, OP_RW, 12'h340, 64'hDEAD_BEEF_1234_5678, 0, 0, 0, 0, 0, 0));
    vecs.push_back(rd(12'h340, 0, 64'hDEAD_BEEF_1234_5678));
    vecs.push_back(mk(1, 0, OP_RC, 12'h340, 64'hFFFF_0000_0000_0000, 0, 0, 0, 0, 0, 64'hDEAD_BEEF_1234_5678));
    vecs.push_back(rd(12'h340, 0, 64'h0000_BEEF_1234_5678));
    vecs.push_back(mk(0, 64'h8000_0900, OP_ECALL, 0, 0, 0, 0, 0, 0, 0, 0));               // not valid
    vecs.push_back(rd(12'h341, 0, 64'h8000_0400));
    vecs.push_back(mk(1, 0, OP_RW, 12'h341, 64'h8000_0107, 0, 0, 0, 0, 0, 64'h8000_0400));
    vecs.push_back(rd(12'h341, 0, 64'h8000_0104));                                        // low bits 0
    vecs.push_back(mk(1, 0, OP_RW, 12'h305, 64'h8000_2003, 0, 0, 0, 0, 0, 64'h8000_1001));
    vecs.push_back(rd(12'h305, 0, 64'h8000_2001));                                        // bit1 0
    vecs.push_back(mk(1, 64'h8000_0A00, OP_RW, 12'h344, 64'h1, 0, 1, 1, 0, 64'h8000_2000, 0)); // RW mip
    vecs.push_back(rd(12'h342, 0, 64'd2));

    // Reset: outputs must be deasserted even with a live ECALL / CSR read
    rst_n      = 1'b0;
    inst_valid = 1'b1;
    pc         = 64'h8000_0000;
    csr_op     = OP_ECALL;
    csr_addr   = 12'h0;
    csr_wsrc   = 64'h0;
    mtip       = 1'b0;
    #3;
    check("rst_redirect",    -1, 64'(redirect),  64'h0);
    check("rst_redirect_pc", -1, redirect_pc,    64'h0);
    check("rst_illegal",     -1, 64'(illegal),   64'h0);
    check("rst_irq_taken",   -1, 64'(irq_taken), 64'h0);
    csr_op   = OP_RS;
    csr_addr = 12'h300;
    #1;
    check("rst_csr_rdata",   -1, csr_rdata,      64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Asynchronous reset in the middle of an ECALL
    inst_valid = 1'b1;
    pc         = 64'h8000_0C00;
    csr_op     = OP_ECALL;
    csr_addr   = 12'h0;
    csr_wsrc   = 64'h0;
    mtip       = 1'b0;
    #2;
    check("ecall_redirect",    200, 64'(redirect), 64'h1);
    check("ecall_redirect_pc", 200, redirect_pc,   64'h8000_2000);
    rst_n = 1'b0;
    #1;
    check("arst_redirect",    201, 64'(redirect), 64'h0);
    check("arst_redirect_pc", 201, redirect_pc,   64'h0);
    check("arst_illegal",     201, 64'(illegal),  64'h0);
    inst_valid = 1'b0;
    csr_op     = OP_NONE;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    vecs.delete();
`ifdef CSR_COUNTERS_EN
    vecs.push_back(rd(12'hB00, 0, 64'h0));                                                // mcycle cleared
`endif
    vecs.push_back(rd(12'h305, 0, 64'h0));
    vecs.push_back(rd(12'h300, 0, MS));
    vecs.push_back(rd(12'h304, 0, 64'h0));
    vecs.push_back(rd(12'h340, 0, 64'h0));
    vecs.push_back(rd(12'h341, 0, 64'h0));
    vecs.push_back(rd(12'h342, 0, 64'h0));
    vecs.push_back(rd(12'h343, 0, 64'h0));
    vecs.push_back(mk(1, 64'h10, OP_ECALL, 0, 0, 0, 1, 0, 0, 64'h0, 0));                  // base back to 0
    vecs.push_back(rd(12'h341, 0, 64'h10));

    foreach (vecs[i]) run_vec(vecs[i], 300 + i);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
